// File: rtl/boid_display_reader_pkg.sv
// Shared constants and swap-FSM encoding for the boid display read side.
package boid_display_reader_pkg;

  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = 19;

  localparam logic [11:0] RGB_BOID = 12'hFFF;
  localparam logic [11:0] RGB_BG   = 12'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SWAP = 2'd3
  } swap_state_t;

endpackage

// File: rtl/boid_swap_ctrl.sv
// Frame-end handshake with the display-memory writer: request, wait (with
// timeout), then flip the displayed buffer.
import boid_display_reader_pkg::*;

module boid_swap_ctrl #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       writer_done,
  output logic       screen_end_out,
  output logic       buf_sel,
  output logic [7:0] missed_frames,
  output logic       timeout_flag
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  swap_state_t      state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit        = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign screen_end_out = (state == REQ);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_end) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (writer_done) state_next = SWAP;
               else if (tmo_hit) state_next = IDLE;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      buf_sel       <= 1'b0;
      missed_frames <= 8'd0;
      timeout_flag  <= 1'b0;
    end else begin
      state <= state_next;

      if (state == REQ)
        tmo_cnt <= '0;
      else if (state == WAIT && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;

      // buf_sel flips on the edge that enters SWAP, so it is stable for the
      // whole SWAP cycle; writer_done has priority over a coincident timeout.
      if (state_next == SWAP && state == WAIT) begin
        buf_sel      <= ~buf_sel;
        timeout_flag <= 1'b0;
      end else if (state == WAIT && tmo_hit) begin
        timeout_flag <= 1'b1;
      end

      if (frame_end && state != IDLE && missed_frames != 8'hFF)
        missed_frames <= missed_frames + 8'd1;
    end
  end

endmodule

// File: rtl/boid_display_reader.sv
// Scan-position to display-RAM address generation, latency-aligned colour
// output, and the buffer swap handshake toward the writer.
import boid_display_reader_pkg::*;

module boid_display_reader #(
  parameter int          VIDEO_WIDTH    = boid_display_reader_pkg::VIDEO_WIDTH,
  parameter int          VIDEO_HEIGHT   = boid_display_reader_pkg::VIDEO_HEIGHT,
  parameter int          ADDR_WIDTH     = 19,
  parameter int          RAM_LATENCY    = 1,
  parameter logic [11:0] BOID_COLOR     = RGB_BOID,
  parameter logic [11:0] BG_COLOR       = RGB_BG,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [9:0]            pix_x,
  input  logic [8:0]            pix_y,
  input  logic                  pix_active,
  input  logic                  frame_end,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  output logic [11:0]           rgb_out,
  output logic                  screen_end_out,
  input  logic                  writer_done,
  output logic                  buf_sel,
  output logic [7:0]            missed_frames,
  output logic                  timeout_flag
);

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic [RAM_LATENCY:0]  vld_pipe;

  assign in_range  = pix_active && (int'(pix_x) < VIDEO_WIDTH) && (int'(pix_y) < VIDEO_HEIGHT);
  assign addr_calc = ADDR_WIDTH'(pix_x) + ADDR_WIDTH'(pix_y) * ADDR_WIDTH'(VIDEO_WIDTH);

  // vld_pipe[0] tracks read_addr; vld_pipe[RAM_LATENCY] lines up with read_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_addr <= '0;
      vld_pipe  <= '0;
      rgb_out   <= BG_COLOR;
    end else begin
      if (in_range) read_addr <= addr_calc;
      vld_pipe <= {vld_pipe[RAM_LATENCY-1:0], in_range};
      rgb_out  <= (vld_pipe[RAM_LATENCY] && read_data) ? BOID_COLOR : BG_COLOR;
    end
  end

  boid_swap_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_swap_ctrl (
    .clock          (clock),
    .reset          (reset),
    .frame_end      (frame_end),
    .writer_done    (writer_done),
    .screen_end_out (screen_end_out),
    .buf_sel        (buf_sel),
    .missed_frames  (missed_frames),
    .timeout_flag   (timeout_flag)
  );

endmodule

// File: tb/tb_boid_display_reader.sv
// Directed bench: dut_a uses the default timeout, dut_b a 16-cycle timeout.
module tb_boid_display_reader;

  logic        clock, reset;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_active, frame_end, read_data, writer_done;

  logic [18:0] a_addr, b_addr;
  logic [11:0] a_rgb, b_rgb;
  logic        a_se, b_se, a_buf, b_buf, a_tflag, b_tflag;
  logic [7:0]  a_missed, b_missed;

  int checks = 0;
  int errors = 0;
  int se_seen;

  boid_display_reader dut_a (
    .clock(clock), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .frame_end(frame_end), .read_addr(a_addr),
    .read_data(read_data), .rgb_out(a_rgb), .screen_end_out(a_se),
    .writer_done(writer_done), .buf_sel(a_buf), .missed_frames(a_missed),
    .timeout_flag(a_tflag)
  );

  boid_display_reader #(.TIMEOUT_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .frame_end(frame_end), .read_addr(b_addr),
    .read_data(read_data), .rgb_out(b_rgb), .screen_end_out(b_se),
    .writer_done(writer_done), .buf_sel(b_buf), .missed_frames(b_missed),
    .timeout_flag(b_tflag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // frame_end, then writer_done sampled 5 cycles later
  task automatic handshake(input logic exp_buf, input logic with_frame);
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    chk("hs_se_req", a_se, 1);
    tick;
    chk("hs_se_wait", a_se, 0);
    repeat (3) tick;
    chk("hs_buf_pre", a_buf, !exp_buf);
    writer_done = 1'b1;
    frame_end   = with_frame;
    tick;
    writer_done = 1'b0;
    frame_end   = 1'b0;
    chk("hs_buf", a_buf, exp_buf);
    tick;
    chk("hs_se_after", a_se, 0);
  endtask

  initial begin
    reset = 1'b1; pix_x = '0; pix_y = '0; pix_active = 1'b0;
    frame_end = 1'b0; read_data = 1'b0; writer_done = 1'b0;
    repeat (2) tick;
    chk("rst_addr", a_addr, 0);
    chk("rst_rgb", a_rgb, 12'h000);
    chk("rst_se", a_se, 0);
    chk("rst_buf", a_buf, 0);
    chk("rst_missed", a_missed, 0);
    chk("rst_tflag", a_tflag, 0);
    reset = 1'b0;
    tick;

    // address and latency
    pix_x = 10'd10; pix_y = 9'd10; pix_active = 1'b1;
    tick;
    pix_active = 1'b0;
    chk("addr_10_10", a_addr, 6410);
    chk("rgb_lat1", a_rgb, 12'h000);
    tick;
    chk("rgb_lat2", a_rgb, 12'h000);
    read_data = 1'b1;
    tick;
    read_data = 1'b0;
    chk("rgb_lat3", a_rgb, 12'hFFF);

    // last pixel, then out-of-range inputs with read_data forced high
    pix_x = 10'd639; pix_y = 9'd479; pix_active = 1'b1;
    tick;
    chk("addr_corner", a_addr, 307199);
    pix_x = 10'd640; pix_y = 9'd5;
    tick;
    read_data = 1'b1;
    pix_x = 10'd20; pix_y = 9'd20; pix_active = 1'b0;
    tick;
    chk("rgb_corner", a_rgb, 12'hFFF);
    chk("addr_hold_x640", a_addr, 307199);
    pix_x = 10'd100; pix_y = 9'd480; pix_active = 1'b1;
    tick;
    pix_active = 1'b0;
    chk("rgb_x640", a_rgb, 12'h000);
    chk("addr_hold_inact", a_addr, 307199);
    tick;
    chk("rgb_inactive", a_rgb, 12'h000);
    tick;
    chk("rgb_y480", a_rgb, 12'h000);
    chk("addr_hold_y480", a_addr, 307199);
    read_data = 1'b0;

    // handshakes
    handshake(1'b1, 1'b0);
    writer_done = 1'b1;
    tick;
    writer_done = 1'b0;
    chk("done_in_idle", a_buf, 1);
    handshake(1'b0, 1'b1);
    chk("missed_frame_and_done", a_missed, 1);

    // dropped frames while waiting
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    chk("drop_se_req", a_se, 1);
    tick;
    frame_end = 1'b1;
    se_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (a_se) se_seen++;
      if (i == 9) chk("missed_11", a_missed, 11);
    end
    frame_end = 1'b0;
    chk("missed_sat", a_missed, 255);
    chk("no_extra_req", se_seen, 0);
    writer_done = 1'b1;
    tick;
    writer_done = 1'b0;
    chk("drop_swap", a_buf, 1);
    tick;

    // put a lit pixel on rgb_out, park the FSM in WAIT, then reset mid-cycle
    pix_x = 10'd1; pix_y = 9'd0; pix_active = 1'b1;
    tick;
    pix_active = 1'b0;
    tick;
    read_data = 1'b1;
    tick;
    read_data = 1'b0;
    chk("pre_rst_rgb", a_rgb, 12'hFFF);
    chk("pre_rst_addr", a_addr, 1);
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    tick;
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_buf", a_buf, 0);
    chk("mid_rst_se", a_se, 0);
    chk("mid_rst_rgb", a_rgb, 12'h000);
    chk("mid_rst_addr", a_addr, 0);
    chk("mid_rst_missed", a_missed, 0);
    tick;
    reset = 1'b0;
    writer_done = 1'b1;
    tick;
    writer_done = 1'b0;
    chk("post_rst_idle", a_buf, 0);
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    chk("post_rst_req", a_se, 1);

    // timeout on dut_b
    reset = 1'b1;
    tick;
    reset = 1'b0;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    chk("tmo_se", b_se, 1);
    repeat (16) tick;
    chk("tmo_not_yet", b_tflag, 0);
    tick;
    chk("tmo_flag", b_tflag, 1);
    chk("tmo_buf", b_buf, 0);
    writer_done = 1'b1;
    tick;
    writer_done = 1'b0;
    chk("tmo_idle_done", b_buf, 0);
    chk("tmo_flag_held", b_tflag, 1);
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    repeat (16) tick;
    writer_done = 1'b1;
    tick;
    writer_done = 1'b0;
    chk("done_beats_tmo_buf", b_buf, 1);
    chk("done_clears_flag", b_tflag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
